aes_key_sched: RTL and testbench

- Key-load initiator for the AES round pipeline: accepts one 128-bit AES-128 cipher key through a valid/ready handshake.
- Expands the key forward into round keys K0..K10 and broadcasts them on a shared key bus, pulsing a per-stage `set_key` strobe.
- Then runs the schedule backwards (K10..K0) without storage and broadcasts with per-stage `set_inv_key` strobes.
- Each round stage's `in_key` / `set_key` / `set_inv_key` is wired to `round_key` and to one bit of the strobe vectors.

---
 rtl/aes_key_sched.sv | 195 +++++++++++++++++++
 tb/tb_aes_key_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched.sv
// aes_key_sched -- AES-128 key-load initiator for the round pipeline.
//
// Accepts one 128-bit cipher key over a valid/ready handshake. It expands
// the key forward (K0..K10) onto a shared broadcast bus, pulsing set_key[i].
// It then walks the schedule backwards (K10..K0) without storing any round
// keys, pulsing set_inv_key[i].
//
// Ports
//   clk, rstn    clock / asynchronous active-low reset
//   key_in       cipher key, FIPS-197 byte order (w0 = [127:96])
//   key_valid    key_in valid
//   key_ready    idle, a key can be accepted
//   round_key    registered broadcast round key
//   set_key      one-hot per-stage encrypt-key load strobe
//   set_inv_key  one-hot per-stage decrypt-key load strobe
//   busy         schedule in progress
//   done         pulse on the final strobe cycle
module aes_key_sched #(
  parameter int NR = 10
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [127:0]  key_in,
  input  logic          key_valid,
  output logic          key_ready,
  output logic [127:0]  round_key,
  output logic [NR:0]   set_key,
  output logic [NR:0]   set_inv_key,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_BWD  = 2'd2;

  localparam logic [3:0]  LAST = 4'(NR);
  localparam logic [NR:0] ONE  = {{NR{1'b0}}, 1'b1};

  // GF(2^8) arithmetic for the S-box: inverse is x^254, then the affine map.
  function automatic logic [7:0] f_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = f_xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] f_sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    // x^254 = x^2 * x^4 * ... * x^128; zero maps to zero.
    for (int i = 1; i < 8; i++) begin
      sq  = f_gmul(sq, sq);
      inv = f_gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] f_rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  logic [1:0]   r_state;
  logic [3:0]   r_cnt;
  logic [127:0] r_key;
  logic [NR:0]  r_set;
  logic [NR:0]  r_inv;
  logic         r_done;
  logic         r_rdy;

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_sub_src, w_rot, w_sub, w_t;
  logic [3:0]   w_rc_idx;
  logic [31:0]  w_f0, w_f1, w_f2, w_f3;
  logic [31:0]  w_b0, w_b1, w_b2, w_b3;

  assign {w_w0, w_w1, w_w2, w_w3} = r_key;

  // One shared SubWord: forward uses w3. Backward needs the previous w3,
  // which is w3^w2 of the current key.
  assign w_sub_src = (r_state == S_BWD) ? (w_w3 ^ w_w2) : w_w3;
  assign w_rot     = {w_sub_src[23:0], w_sub_src[31:24]};
  assign w_sub     = {f_sbox(w_rot[31:24]), f_sbox(w_rot[23:16]),
                      f_sbox(w_rot[15:8]),  f_sbox(w_rot[7:0])};
  assign w_rc_idx  = (r_state == S_BWD) ? (LAST - r_cnt) : (r_cnt + 4'd1);
  assign w_t       = w_sub ^ {f_rcon(w_rc_idx), 24'h0};

  assign w_f0 = w_w0 ^ w_t;
  assign w_f1 = w_w1 ^ w_f0;
  assign w_f2 = w_w2 ^ w_f1;
  assign w_f3 = w_w3 ^ w_f2;

  assign w_b3 = w_w3 ^ w_w2;
  assign w_b2 = w_w2 ^ w_w1;
  assign w_b1 = w_w1 ^ w_w0;
  assign w_b0 = w_w0 ^ w_t;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_key   <= '0;
      r_set   <= '0;
      r_inv   <= '0;
      r_done  <= 1'b0;
      r_rdy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (key_valid && r_rdy) begin
            r_state <= S_FWD;
            r_cnt   <= '0;
            r_key   <= key_in;
            r_set   <= ONE;
            r_rdy   <= 1'b0;
          end else begin
            r_rdy   <= 1'b1;
          end
        end
        S_FWD: begin
          if (r_cnt == LAST) begin
            // K10 stays on the bus and becomes the first decrypt key.
            r_state <= S_BWD;
            r_cnt   <= '0;
            r_set   <= '0;
            r_inv   <= ONE;
          end else begin
            r_cnt   <= r_cnt + 4'd1;
            r_key   <= {w_f0, w_f1, w_f2, w_f3};
            r_set   <= {r_set[NR-1:0], 1'b0};
          end
        end
        S_BWD: begin
          if (r_cnt == LAST) begin
            // Scrub the bus so no key material lingers after the schedule.
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_key   <= '0;
            r_inv   <= '0;
            r_done  <= 1'b0;
            r_rdy   <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + 4'd1;
            r_key   <= {w_b0, w_b1, w_b2, w_b3};
            r_inv   <= {r_inv[NR-1:0], 1'b0};
            r_done  <= (r_cnt == LAST - 4'd1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_key   <= '0;
          r_set   <= '0;
          r_inv   <= '0;
          r_done  <= 1'b0;
          r_rdy   <= 1'b1;
        end
      endcase
    end
  end

  assign key_ready   = r_rdy;
  assign round_key   = r_key;
  assign set_key     = r_set;
  assign set_inv_key = r_inv;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;

endmodule

// File: tb/tb_aes_key_sched.sv
// tb_aes_key_sched -- directed vectors plus a per-cycle reference model.
// The model computes the full FIPS-197 key expansion (table S-box) at accept
// time and derives every output from the number of cycles since the accept.
module tb_aes_key_sched;
  localparam int NR = 10;

  logic          clk = 1'b0;
  logic          rstn;
  logic [127:0]  key_in;
  logic          key_valid;
  logic          key_ready;
  logic [127:0]  round_key;
  logic [NR:0]   set_key;
  logic [NR:0]   set_inv_key;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  aes_key_sched #(.NR(NR)) dut (
    .clk(clk), .rstn(rstn), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .round_key(round_key), .set_key(set_key),
    .set_inv_key(set_inv_key), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] SBOX [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  logic [7:0] RC [0:9] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_K1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_K1    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_K10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_K1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

  // Textbook word-wise expansion into all eleven round keys.
  function automatic logic [10:0][127:0] expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [10:0][127:0] rk;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {RC[i/4-1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  // Model: phase = cycles since accept (1..22), 0 when idle.
  logic [10:0][127:0] m_keys = '0;
  int   m_phase = 0;
  logic m_rdy   = 1'b0;

  always @(posedge clk or negedge rstn) begin
    int nph;
    if (!rstn) begin
      m_phase <= 0;
      m_rdy   <= 1'b0;
    end else begin
      nph = m_phase;
      if (m_phase == 0 && m_rdy && key_valid) begin
        m_keys <= expand(key_in);
        nph = 1;
      end else if (m_phase == 22) nph = 0;
      else if (m_phase != 0)    nph = m_phase + 1;
      m_phase <= nph;
      m_rdy   <= (nph == 0);
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [127:0] e_rk;
    logic [NR:0]  e_set, e_inv;
    if (rstn) begin
      e_rk = '0; e_set = '0; e_inv = '0;
      if (m_phase >= 1 && m_phase <= 11) begin
        e_rk = m_keys[m_phase-1];
        e_set[m_phase-1] = 1'b1;
      end else if (m_phase >= 12) begin
        e_rk = m_keys[22-m_phase];
        e_inv[m_phase-12] = 1'b1;
      end
      chk("sb_round_key", round_key, e_rk);
      chk("sb_set_key", 128'(set_key), 128'(e_set));
      chk("sb_set_inv_key", 128'(set_inv_key), 128'(e_inv));
      chk("sb_done", 128'(done), 128'(m_phase == 22));
      chk("sb_busy", 128'(busy), 128'(m_phase != 0));
      chk("sb_key_ready", 128'(key_ready), 128'(m_rdy));
      chk("sb_onehot", 128'($countones(set_key | set_inv_key) <= 1), 128'(1));
      chk("sb_idle_quiet", 128'(key_ready && |(set_key | set_inv_key)), 128'(0));
      chk("sb_done_last", 128'(done && !set_inv_key[NR]), 128'(0));
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_round_key"}, round_key, 128'h0);
    chk({tag, "_set_key"}, 128'(set_key), 128'h0);
    chk({tag, "_set_inv_key"}, 128'(set_inv_key), 128'h0);
    chk({tag, "_busy"}, 128'(busy), 128'h0);
    chk({tag, "_done"}, 128'(done), 128'h0);
    chk({tag, "_key_ready"}, 128'(key_ready), 128'h0);
  endtask

  // Present a key and return right at the accepting posedge.
  task automatic send_key(input logic [127:0] k);
    bit ok;
    ok = 1'b0;
    key_in = k;
    key_valid = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (key_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: got no key_ready expected accept within 60 cycles");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (key_ready) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout: got busy expected idle within 60 cycles");
    end
  endtask

  initial begin
    rstn = 1'b0; key_valid = 1'b0; key_in = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rstn = 1'b1;

    // FIPS-197 A.1 key, second key (all zero) held valid throughout.
    send_key(KEY_A1);
    #1 key_in = 128'h0;
    chk("model_A1_K1", m_keys[1], A1_K1);
    chk("model_A1_K10", m_keys[10], A1_K10);
    @(negedge clk);                 // T+1
    chk("a1_fwd0_key", round_key, KEY_A1);
    chk("a1_fwd0_strobe", 128'(set_key), 128'h1);
    @(negedge clk);                 // T+2
    chk("a1_fwd1_key", round_key, A1_K1);
    chk("a1_fwd1_strobe", 128'(set_key), 128'h2);
    repeat (9) @(negedge clk);      // T+11
    chk("a1_fwd10_key", round_key, A1_K10);
    chk("a1_fwd10_strobe", 128'(set_key), 128'h400);
    @(negedge clk);                 // T+12
    chk("a1_bwd0_key", round_key, A1_K10);
    chk("a1_bwd0_strobe", 128'(set_inv_key), 128'h1);
    repeat (9) @(negedge clk);      // T+21
    chk("a1_bwd9_key", round_key, A1_K1);
    chk("a1_bwd9_strobe", 128'(set_inv_key), 128'h200);
    @(negedge clk);                 // T+22
    chk("a1_bwd10_key", round_key, KEY_A1);
    chk("a1_bwd10_strobe", 128'(set_inv_key), 128'h400);
    chk("a1_done", 128'(done), 128'h1);
    @(negedge clk);                 // T+23
    chk("a1_scrub", round_key, 128'h0);
    chk("a1_ready_again", 128'(key_ready), 128'h1);
    @(posedge clk);                 // edge T+23: zero key accepted
    #1 key_valid = 1'b0; key_in = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    @(negedge clk);                 // T+24
    chk("z_fwd0_strobe", 128'(set_key), 128'h1);
    chk("z_fwd0_key", round_key, 128'h0);
    @(negedge clk);
    chk("z_fwd1_key", round_key, Z_K1);
    repeat (9) @(negedge clk);
    chk("z_fwd10_key", round_key, Z_K10);
    @(negedge clk);
    chk("z_bwd0_key", round_key, Z_K10);
    chk("z_bwd0_strobe", 128'(set_inv_key), 128'h1);
    wait_idle();

    // Reset mid-schedule.
    send_key(KEY_A1);
    #1 key_valid = 1'b0;
    repeat (6) @(negedge clk);      // T+6
    #1 rstn = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk);
    #1 rstn = 1'b1;

    send_key(KEY_C1);
    #1 key_valid = 1'b0;
    chk("model_C1_K1", m_keys[1], C1_K1);
    repeat (2) @(negedge clk);      // T+2
    chk("c1_fwd1_key", round_key, C1_K1);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1);
  end
endmodule
